// File: rtl/alu_status_unit.sv
// alu_status_unit
//   Buffers ALU results (result, opcode, flags) in a small circular FIFO and
//   keeps a status register holding the flags of the most recently accepted
//   entry. It also tracks sticky carry/overflow bits and a saturating count of
//   offers that were rejected because the buffer was full.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid / in_ready           upstream handshake
//   in_y, in_op, in_flags         entry fields; flags are {carry, zero, sign, overflow}
//   out_valid / out_ready         downstream handshake
//   out_y, out_op, out_flags      head entry fields (combinational from storage)
//   flags_q                       status register (flags of last push)
//   cond_sel / cond_true          condition code selector and its result on flags_q
//   sticky_clr                    clears sticky bits and the overrun counter
//   sticky_c, sticky_v            sticky carry / overflow
//   overrun_cnt                   saturating count of rejected offers
//   count                         number of entries held

module alu_status_unit #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_y,
  input  logic [2:0]               in_op,
  input  logic [3:0]               in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_y,
  output logic [2:0]               out_op,
  output logic [3:0]               out_flags,
  output logic [3:0]               flags_q,
  input  logic [2:0]               cond_sel,
  output logic                     cond_true,
  input  logic                     sticky_clr,
  output logic                     sticky_c,
  output logic                     sticky_v,
  output logic [3:0]               overrun_cnt,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Positions of the individual flags inside a flags word.
  localparam int F_C = 3;
  localparam int F_Z = 2;
  localparam int F_S = 1;
  localparam int F_V = 0;

  logic [3:0]    y_mem     [DEPTH];
  logic [2:0]    op_mem    [DEPTH];
  logic [3:0]    flags_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          push;
  logic          pop;
  logic          reject;

  // Handshake decode. A full buffer never accepts, so a pop from full only
  // frees a slot for the following cycle.
  assign in_ready  = (count < FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign reject    = in_valid && !in_ready;

  // The head entry is read straight from storage; since the read pointer only
  // moves on a pop, the outputs hold while the consumer stalls.
  assign out_y     = y_mem[rd_ptr];
  assign out_op    = op_mem[rd_ptr];
  assign out_flags = flags_mem[rd_ptr];

  // Entry storage. Not reset: contents are only observable through the
  // pointers, which are reset, so stale data can never be presented.
  always_ff @(posedge clk) begin
    if (push) begin
      y_mem[wr_ptr]     <= in_y;
      op_mem[wr_ptr]    <= in_op;
      flags_mem[wr_ptr] <= in_flags;
    end
  end

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
  // naturally at their width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Status register and sticky bits. A setting push takes priority over a
  // clear in the same cycle so no carry/overflow event is ever lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q  <= '0;
      sticky_c <= 1'b0;
      sticky_v <= 1'b0;
    end else begin
      if (push) begin
        flags_q <= in_flags;
      end
      if (push && in_flags[F_C]) begin
        sticky_c <= 1'b1;
      end else if (sticky_clr) begin
        sticky_c <= 1'b0;
      end
      if (push && in_flags[F_V]) begin
        sticky_v <= 1'b1;
      end else if (sticky_clr) begin
        sticky_v <= 1'b0;
      end
    end
  end

  // Overrun counter: a rejection coinciding with a clear counts as the first
  // event after the clear, giving 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_cnt <= '0;
    end else if (reject) begin
      if (sticky_clr) begin
        overrun_cnt <= 4'd1;
      end else if (overrun_cnt != 4'd15) begin
        overrun_cnt <= overrun_cnt + 4'd1;
      end
    end else if (sticky_clr) begin
      overrun_cnt <= '0;
    end
  end

  // Condition code evaluation on the status register.
  always_comb begin
    cond_true = 1'b1;
    case (cond_sel)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = flags_q[F_Z];
      3'd2:    cond_true = !flags_q[F_Z];
      3'd3:    cond_true = flags_q[F_C];
      3'd4:    cond_true = !flags_q[F_C];
      3'd5:    cond_true = flags_q[F_S];
      3'd6:    cond_true = flags_q[F_V];
      3'd7:    cond_true = flags_q[F_S] ^ flags_q[F_V];
      default: cond_true = 1'b1;
    endcase
  end

endmodule

// File: doc/alu_status_unit.md
ALU_STATUS_UNIT -- requirements
Module: alu_status_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of result entries buffered (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream ALU result and flags valid this cycle.
REQ-005 SHALL have port in_ready  output  1  unit can accept an entry this cycle.
REQ-006 SHALL have port in_y  input  4  ALU result.
REQ-007 SHALL have port in_op  input  3  opcode that produced the result.
REQ-008 SHALL have port in_flags  input  4  {carry, zero, sign, overflow} from the flag stage.
REQ-009 SHALL have port out_valid  output  1  head entry available.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the head entry.
REQ-011 SHALL have port out_y / out_op / out_flags  output  4/3/4  head entry fields.
REQ-012 SHALL have port flags_q  output  4  status register: flags of the most recently accepted entry.
REQ-013 SHALL have port cond_sel  input  3  condition code selector.
REQ-014 SHALL have port cond_true  output  1  selected condition evaluated on flags_q.
REQ-015 SHALL have port sticky_clr  input  1  clears sticky flags and overrun counter.
REQ-016 SHALL have port sticky_c / sticky_v  output  1/1  sticky carry / overflow.
REQ-017 SHALL have port overrun_cnt  output  4  saturating count of rejected offers.
REQ-018 SHALL have port count  output  $clog2(DEPTH)+1  entries currently held.

Function
REQ-019 SHALL store entries in a DEPTH-deep circular FIFO; read and write pointers wrap modulo DEPTH.
REQ-020 SHALL assert in_ready exactly when count < DEPTH; a push occurs when in_valid && in_ready.
REQ-021 SHALL assert out_valid exactly when count != 0; a pop occurs when out_valid && out_ready.
REQ-022 SHALL drive out_y/out_op/out_flags combinationally from the head entry; values are don't-care when out_valid=0.
REQ-023 SHALL make a pushed entry visible at out_* one cycle after the push edge when empty (latency 1, no same-cycle bypass).
REQ-024 SHALL, on simultaneous push and pop, advance both pointers and leave count unchanged, including when count=DEPTH is not reachable (full blocks push, so full+pop only decrements).
REQ-025 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-026 SHALL load flags_q <= in_flags on every push; flags_q unchanged otherwise.
REQ-027 SHALL evaluate cond_true on flags_q: 0 always=1, 1 EQ=Z, 2 NE=!Z, 3 CS=C, 4 CC=!C, 5 MI=S, 6 VS=V, 7 LT=S^V.
REQ-028 SHALL set sticky_c / sticky_v on a push whose carry / overflow bit is 1; cleared by sticky_clr; set wins over simultaneous clear.
REQ-029 SHALL increment overrun_cnt each cycle in_valid=1 and in_ready=0, saturating at 15; sticky_clr zeroes it; increment wins over simultaneous clear (result 1).
REQ-030 SHALL ignore in_op content for flag logic; it is carried only as payload.

Reset
REQ-031 SHALL, while rst=1, force count=0, pointers=0, out_valid=0, in_ready=1, flags_q=0, sticky_c=0, sticky_v=0, overrun_cnt=0, cond_true per flags_q=0.
REQ-032 SHALL discard all buffered entries when rst asserts mid-operation; no pop or push completes on a cycle where rst=1.

Verification
REQ-033 Push y=5 flags=0100 into empty unit, out_ready=0 -> next cycle out_valid=1, out_y=5, out_flags=0100, count=1, cond_sel=1 gives cond_true=1.
REQ-034 Push 4 entries (y=1..4), out_ready=0, keep in_valid=1 for 3 more cycles -> in_ready=0, count=4, overrun_cnt=3; then pop all -> y order 1,2,3,4.
REQ-035 With count=2, push and pop same cycle for 6 cycles -> count stays 2, pointers wrap, output order preserved.
REQ-036 Push flags=0001 then flags=0000 -> sticky_v=1, flags_q=0000; sticky_clr with push of flags=0001 same cycle -> sticky_v=1; sticky_clr alone -> sticky_v=0.
REQ-037 Push flags with S=1,V=0 -> cond_sel=7 gives cond_true=1; push S=1,V=1 -> cond_true=0.
REQ-038 Fill 3 entries, assert rst asynchronously mid-cycle -> out_valid=0, count=0, in_ready=1 immediately, no stale entry after release.
